// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver: FSM encoding, prescale
// selection codes and the three-sample majority vote.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   // Code 0 is the reset value and stands for the default ratio of 8.
   typedef enum logic [1:0] {
      PS_8  = 2'd0,
      PS_16 = 2'd1,
      PS_32 = 2'd2
   } presc_sel_e;

   localparam logic [5:0] PRESC_8  = 6'd8;
   localparam logic [5:0] PRESC_16 = 6'd16;
   localparam logic [5:0] PRESC_32 = 6'd32;

   function automatic presc_sel_e presc_encode(input logic [5:0] p);
      case (p)
         PRESC_16: return PS_16;
         PRESC_32: return PS_32;
         default:  return PS_8;
      endcase
   endfunction

   function automatic logic [5:0] presc_value(input presc_sel_e s);
      case (s)
         PS_16:   return PRESC_16;
         PS_32:   return PRESC_32;
         default: return PRESC_8;
      endcase
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter: votes RX at the three mid-bit edges and
// strobes bit_done on the last edge of each bit period.
module uart_rx_sampler
   import uart_rx_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       en_i,
   input  logic       rx_i,
   input  presc_sel_e presc_sel_i,
   output logic       sampled_bit,
   output logic       bit_done
);

   logic [5:0] presc;
   logic [5:0] half;
   logic [5:0] edge_cnt_q, edge_cnt_d;
   logic [1:0] early_q;
   logic       sampled_bit_q;

   assign presc       = presc_value(presc_sel_i);
   assign half        = presc >> 1;
   assign bit_done    = en_i && (edge_cnt_q == presc - 6'd1);
   assign sampled_bit = sampled_bit_q;

   // Counter is parked at zero while idle so the first START cycle is edge 0.
   always_comb begin
      edge_cnt_d = edge_cnt_q + 6'd1;
      if (!en_i || bit_done) begin
         edge_cnt_d = 6'd0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_cnt_q    <= 6'd0;
         early_q       <= 2'b00;
         sampled_bit_q <= 1'b0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         if (en_i && (edge_cnt_q == half - 6'd1)) begin
            early_q[0] <= rx_i;
         end
         if (en_i && (edge_cnt_q == half)) begin
            early_q[1] <= rx_i;
         end
         if (en_i && (edge_cnt_q == half + 6'd1)) begin
            sampled_bit_q <= majority3(early_q[0], early_q[1], rx_i);
         end
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM with optional parity, one-cycle outcome pulses
// registered the cycle after the stop bit's final oversampling edge.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            Prescale,
   input  logic                  parity_enable,
   input  logic                  parity_type,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  parity_error,
   output logic                  framing_error
);

   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

   rx_state_e             state_q;
   presc_sel_e            presc_sel_q;
   logic                  par_en_q;
   logic                  par_type_q;
   logic                  par_err_q;
   logic [BCW-1:0]        bit_cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] p_data_q;
   logic                  data_valid_q;
   logic                  parity_error_q;
   logic                  framing_error_q;

   logic sampled_bit;
   logic bit_done;

   uart_rx_sampler u_sampler (
      .CLK         (CLK),
      .RST         (RST),
      .en_i        (state_q != IDLE),
      .rx_i        (RX_IN),
      .presc_sel_i (presc_sel_q),
      .sampled_bit (sampled_bit),
      .bit_done    (bit_done)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q         <= IDLE;
         presc_sel_q     <= PS_8;
         par_en_q        <= 1'b0;
         par_type_q      <= 1'b0;
         par_err_q       <= 1'b0;
         bit_cnt_q       <= '0;
         shift_q         <= '0;
         p_data_q        <= '0;
         data_valid_q    <= 1'b0;
         parity_error_q  <= 1'b0;
         framing_error_q <= 1'b0;
      end else begin
         data_valid_q    <= 1'b0;
         parity_error_q  <= 1'b0;
         framing_error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // Frame configuration is frozen here for the whole frame.
               if (!RX_IN) begin
                  state_q     <= START;
                  presc_sel_q <= presc_encode(Prescale);
                  par_en_q    <= parity_enable;
                  par_type_q  <= parity_type;
                  par_err_q   <= 1'b0;
                  bit_cnt_q   <= '0;
               end
            end
            START: begin
               if (bit_done) begin
                  state_q <= sampled_bit ? IDLE : DATA;
               end
            end
            DATA: begin
               if (bit_done) begin
                  shift_q <= DATA_WIDTH'({sampled_bit, shift_q} >> 1);
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_q <= '0;
                     state_q   <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BCW'(1);
                  end
               end
            end
            PARITY: begin
               if (bit_done) begin
                  par_err_q <= ((^shift_q) ^ sampled_bit) != par_type_q;
                  state_q   <= STOP;
               end
            end
            STOP: begin
               if (bit_done) begin
                  state_q <= IDLE;
                  if (!sampled_bit) begin
                     framing_error_q <= 1'b1;
                  end else if (par_err_q) begin
                     parity_error_q <= 1'b1;
                  end else begin
                     data_valid_q <= 1'b1;
                     p_data_q     <= shift_q;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign P_DATA        = p_data_q;
   assign data_valid    = data_valid_q;
   assign parity_error  = parity_error_q;
   assign framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames
// checked against a frame-level outcome model.
module tb_uart_rx;
   import uart_rx_pkg::*;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       parity_enable;
   logic       parity_type;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       parity_error;
   logic       framing_error;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_dv, n_pe, n_fe, pulse_cyc, c0;
   logic [7:0] dv_q[$];
   int         dv_cyc_q[$];
   logic [7:0] exp_pdata;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .RX_IN         (RX_IN),
      .Prescale      (Prescale),
      .parity_enable (parity_enable),
      .parity_type   (parity_type),
      .P_DATA        (P_DATA),
      .data_valid    (data_valid),
      .parity_error  (parity_error),
      .framing_error (framing_error)
   );

   always #5 CLK = ~CLK;

   // One clock: observe outputs at the falling edge, then caller may drive.
   task automatic tick();
      @(negedge CLK);
      cyc++;
      if (data_valid) begin
         n_dv++;
         pulse_cyc = cyc;
         dv_q.push_back(P_DATA);
         dv_cyc_q.push_back(cyc);
      end
      if (parity_error) begin
         n_pe++;
         pulse_cyc = cyc;
      end
      if (framing_error) begin
         n_fe++;
         pulse_cyc = cyc;
      end
   endtask

   task automatic clear_mon();
      n_dv = 0; n_pe = 0; n_fe = 0; pulse_cyc = -1;
      dv_q.delete();
      dv_cyc_q.delete();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input logic [5:0] p, input bit pen, input bit ptype);
      Prescale = p; parity_enable = pen; parity_type = ptype;
   endtask

   // Drives one frame with p clocks per bit; scramble flips config mid-frame.
   task automatic send_frame(input int p, input logic [7:0] d, input bit pen,
                             input bit pbit, input bit stopb, input bit scramble);
      c0 = cyc;
      RX_IN = 1'b0;
      repeat (p) tick();
      for (int i = 0; i < 8; i++) begin
         if (scramble && i == 3) begin
            Prescale      = (Prescale == 6'd8) ? 6'd32 : 6'd8;
            parity_enable = ~parity_enable;
            parity_type   = ~parity_type;
         end
         RX_IN = d[i];
         repeat (p) tick();
      end
      if (pen) begin
         RX_IN = pbit;
         repeat (p) tick();
      end
      RX_IN = stopb;
      repeat (p) tick();
      RX_IN = 1'b1;
   endtask

   function automatic bit good_parity(input logic [7:0] d, input bit ptype);
      return (^d) ^ ptype;
   endfunction

   // 0 = accepted, 1 = parity error, 2 = framing error
   function automatic int model_outcome(input logic [7:0] d, input bit pen, input bit ptype,
                                        input bit pbit, input bit stopb);
      if (!stopb) return 2;
      if (pen && (((^d) ^ pbit) != ptype)) return 1;
      return 0;
   endfunction

   task automatic check_outcome(input string tag, input int kind, input int nbits,
                                input int p, input int extra);
      chk({tag, ".dv"},    n_dv, (kind == 0) ? 1 : 0);
      chk({tag, ".pe"},    n_pe, (kind == 1) ? 1 : 0);
      chk({tag, ".fe"},    n_fe, (kind == 2) ? 1 : 0);
      chk({tag, ".pdata"}, P_DATA, exp_pdata);
      chk({tag, ".cyc"},   pulse_cyc, c0 + nbits * p + 1 + extra);
   endtask

   initial begin
      int c1, c2, kind, p;
      logic [7:0] d;
      bit pen, ptype, pbit, stopb;

      RST = 1'b0; RX_IN = 1'b1;
      set_cfg(6'd8, 1'b0, 1'b0);
      exp_pdata = 8'h00;
      clear_mon();
      repeat (3) tick();
      chk("rst.pdata", P_DATA, 8'h00);
      chk("rst.dv", data_valid, 1'b0);
      chk("rst.pe", parity_error, 1'b0);
      chk("rst.fe", framing_error, 1'b0);
      chk("rst.state", 32'(dut.state_q), 32'(IDLE));
      RST = 1'b1;
      repeat (4) tick();

      // 8 clocks per bit, no parity
      set_cfg(6'd8, 1'b0, 1'b0); clear_mon();
      send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      exp_pdata = 8'hA5;
      check_outcome("a5_p8", 0, 10, 8, 0);

      // even parity with a wrong parity bit
      set_cfg(6'd16, 1'b1, 1'b0); clear_mon();
      send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) tick();
      check_outcome("3c_par", 1, 11, 16, 0);

      // stop bit low, then stop low plus bad parity
      set_cfg(6'd8, 1'b0, 1'b0); clear_mon();
      send_frame(8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      check_outcome("55_fe", 2, 10, 8, 0);
      set_cfg(6'd8, 1'b1, 1'b0); clear_mon();
      send_frame(8, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) tick();
      check_outcome("55_fe_par", 2, 11, 8, 0);

      // two-cycle glitch is rejected
      set_cfg(6'd16, 1'b0, 1'b0); clear_mon();
      RX_IN = 1'b0; repeat (2) tick();
      RX_IN = 1'b1; repeat (40) tick();
      chk("glitch.pulses", n_dv + n_pe + n_fe, 0);
      chk("glitch.state", 32'(dut.state_q), 32'(IDLE));

      // back-to-back frames, odd parity, 32 clocks per bit
      set_cfg(6'd32, 1'b1, 1'b1); clear_mon();
      send_frame(32, 8'h00, 1'b1, good_parity(8'h00, 1'b1), 1'b1, 1'b0);
      c1 = c0;
      send_frame(32, 8'hFF, 1'b1, good_parity(8'hFF, 1'b1), 1'b1, 1'b0);
      c2 = c0;
      repeat (4) tick();
      chk("b2b.count", n_dv, 2);
      chk("b2b.errs", n_pe + n_fe, 0);
      chk("b2b.d0", (dv_q.size() > 0) ? dv_q[0] : 8'hxx, 8'h00);
      chk("b2b.d1", (dv_q.size() > 1) ? dv_q[1] : 8'hxx, 8'hFF);
      chk("b2b.t0", (dv_cyc_q.size() > 0) ? dv_cyc_q[0] : -1, c1 + 11 * 32 + 1);
      chk("b2b.t1", (dv_cyc_q.size() > 1) ? dv_cyc_q[1] : -1, c2 + 11 * 32 + 2);
      exp_pdata = 8'hFF;

      // reset during data bit 4 aborts the frame
      set_cfg(6'd8, 1'b0, 1'b0); clear_mon();
      d = 8'h3C;
      RX_IN = 1'b0; repeat (8) tick();
      for (int i = 0; i < 4; i++) begin
         RX_IN = d[i]; repeat (8) tick();
      end
      RX_IN = d[4]; repeat (3) tick();
      RST = 1'b0;
      tick();
      chk("midrst.pdata", P_DATA, 8'h00);
      chk("midrst.state", 32'(dut.state_q), 32'(IDLE));
      RST = 1'b1; RX_IN = 1'b1;
      repeat (20) tick();
      chk("midrst.pulses", n_dv + n_pe + n_fe, 0);
      clear_mon();
      send_frame(8, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      exp_pdata = 8'h81;
      check_outcome("after_rst", 0, 10, 8, 0);

      // unsupported ratio falls back to 8
      set_cfg(6'd12, 1'b0, 1'b0); clear_mon();
      send_frame(8, 8'h6E, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      exp_pdata = 8'h6E;
      check_outcome("presc12", 0, 10, 8, 0);

      // config changes mid-frame are ignored
      set_cfg(6'd16, 1'b1, 1'b0); clear_mon();
      send_frame(16, 8'hC3, 1'b1, good_parity(8'hC3, 1'b0), 1'b1, 1'b1);
      repeat (3) tick();
      exp_pdata = 8'hC3;
      check_outcome("cfg_change", 0, 11, 16, 0);

      for (int n = 0; n < 14; n++) begin
         case ($urandom_range(0, 2))
            0:       p = 8;
            1:       p = 16;
            default: p = 32;
         endcase
         d     = 8'($urandom);
         pen   = 1'($urandom);
         ptype = 1'($urandom);
         pbit  = good_parity(d, ptype) ^ ($urandom_range(0, 3) == 0);
         stopb = ($urandom_range(0, 5) != 0);
         kind  = model_outcome(d, pen, ptype, pbit, stopb);
         set_cfg(6'(p), pen, ptype); clear_mon();
         send_frame(p, d, pen, pbit, stopb, 1'b0);
         repeat (3) tick();
         if (kind == 0) exp_pdata = d;
         check_outcome($sformatf("rand%0d", n), kind, 10 + int'(pen), p, 0);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have port CLK  input  1  receiver oversampling clock, rising-edge.
REQ-003 SHALL have port RST  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port RX_IN  input  1  serial line, idle high, externally synchronised.
REQ-005 SHALL have port Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 SHALL have port parity_enable  input  1  1 = parity bit present.
REQ-007 SHALL have port parity_type  input  1  0 = even, 1 = odd.
REQ-008 SHALL have port P_DATA  output  DATA_WIDTH  last accepted byte.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse per accepted frame.
REQ-010 SHALL have port parity_error  output  1  one-cycle pulse, parity mismatch.
REQ-011 SHALL have port framing_error  output  1  one-cycle pulse, stop bit sampled 0.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL keep edge_cnt (0..Prescale-1) and bit_cnt (0..DATA_WIDTH-1); edge_cnt wraps at Prescale-1, advancing bit_cnt in DATA.
REQ-014 IDLE: RX_IN==0 -> START next cycle, edge_cnt=0; Prescale, parity_enable, parity_type latched in that cycle; mid-frame config changes ignored.
REQ-015 Each bit SHALL be majority vote of RX_IN at edge_cnt = P/2-1, P/2, P/2+1.
REQ-016 START: voted 1 -> IDLE at edge_cnt==P-1, no outputs (glitch reject); voted 0 -> DATA.
REQ-017 DATA: bits shifted LSB-first; after bit DATA_WIDTH-1 -> PARITY if parity enabled, else STOP.
REQ-018 PARITY: error when XOR(data bits, received parity bit) != parity_type; flag held until frame end.
REQ-019 STOP: at edge_cnt==P-1 -> IDLE; next cycle exactly one outcome: framing_error if stop voted 0; else parity_error if flagged; else data_valid and P_DATA updated.
REQ-020 framing_error SHALL take priority; P_DATA SHALL change only on data_valid.
REQ-021 Latency: data_valid high the cycle after the STOP bit's last edge_cnt.
REQ-022 Prescale other than 8/16/32 SHALL be treated as 8.
REQ-023 Back-to-back frames (start bit directly after stop) SHALL be received without loss.

Reset
REQ-024 On RST low: state IDLE, counters 0, P_DATA 0, data_valid/parity_error/framing_error 0, latched config 0 (Prescale 8).
REQ-025 Reset mid-frame SHALL abort it with no pulse; first frame after release received normally.

Structure
REQ-026 Shared package SHALL hold state encoding, legal prescale constants, majority-vote function.
REQ-027 Sub-module uart_rx_sampler SHALL own edge_cnt and majority voting and output sampled_bit plus bit_done strobe.

Verification
REQ-028 P=8, no parity, 0xA5 -> data_valid 1 cycle, P_DATA=0xA5, timing per REQ-021, no error pulses.
REQ-029 P=16, even parity, 0x3C with parity bit 1 -> parity_error pulse, no data_valid, P_DATA unchanged.
REQ-030 P=8, 0x55, stop bit 0 -> framing_error pulse only; with bad parity too, framing_error only.
REQ-031 RX_IN low 2 cycles then high (P=16) -> no output pulses, FSM back in IDLE.
REQ-032 P=32, odd parity, 0x00 then 0xFF back-to-back -> two data_valid pulses, P_DATA 0x00 then 0xFF.
REQ-033 RST asserted during DATA bit 4, released, then 0x81 sent at P=8 -> no pulse for aborted frame, data_valid with P_DATA=0x81.
